// File: rtl/bcd_increment_sequencer_if.sv
// Handshake/bus bundle between the trigger front end and the BCD increment sequencer.
interface bcd_increment_sequencer_if #(parameter int DIGITS = 6);
    logic                  inc_req;
    logic [DIGITS-1:0]     digit_sel;
    logic                  ref_req;
    logic                  clear;
    logic [4*DIGITS-1:0]   value;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic                  inc_drop;

    modport master (output inc_req, digit_sel, ref_req, clear,
                    input  value, busy, done, overflow, inc_drop);
    modport slave  (input  inc_req, digit_sel, ref_req, clear,
                    output value, busy, done, overflow, inc_drop);
endinterface

// File: rtl/bcd_increment_sequencer.sv
// Applies a digit-mask increment to a packed BCD register, rippling one digit per clock,
// and publishes a display snapshot only when no carry is in flight.
module bcd_increment_sequencer #(
    parameter int DIGITS = 6
) (
    input  logic clk,
    input  logic rst_n,
    bcd_increment_sequencer_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [4*DIGITS-1:0] r_work;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_pend;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_ref_pend;
    logic                r_ovf;
    logic                r_inc_drop;

    logic [3:0]          w_dig;
    logic [4:0]          w_sum;
    logic                w_carry;
    logic [3:0]          w_dig_nxt;
    logic [4*DIGITS-1:0] w_work_nxt;

    always_comb begin
        w_dig      = r_work[4*r_idx +: 4];
        w_sum      = {1'b0, w_dig} + {4'b0, r_pend[r_idx]} + {4'b0, r_carry};
        w_carry    = (w_sum >= 5'd10);
        w_dig_nxt  = w_carry ? 4'(w_sum - 5'd10) : w_sum[3:0];
        w_work_nxt = r_work;
        w_work_nxt[4*r_idx +: 4] = w_dig_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_work     <= '0;
            r_value    <= '0;
            r_pend     <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_ref_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_inc_drop <= 1'b0;
        end else if (bus.clear) begin
            r_state    <= S_IDLE;
            r_work     <= '0;
            r_value    <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_ref_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_inc_drop <= 1'b0;
        end else begin
            r_inc_drop <= bus.inc_req && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.ref_req) r_value <= r_work;
                    if (bus.inc_req) begin
                        r_pend  <= bus.digit_sel;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_work  <= w_work_nxt;
                    r_carry <= w_carry;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_state <= S_DONE;
                        if (w_carry) r_ovf <= 1'b1;
                        // Snapshot lands with the final digit so it is visible alongside done.
                        if (r_ref_pend || bus.ref_req) begin
                            r_value    <= w_work_nxt;
                            r_ref_pend <= 1'b0;
                        end
                    end else if (bus.ref_req) begin
                        r_ref_pend <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.ref_req) r_value <= r_work;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.value    = r_value;
    assign bus.busy     = (r_state == S_SCAN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.overflow = r_ovf;
    assign bus.inc_drop = r_inc_drop;
endmodule
